// File: rtl/cpu_iob_pkg.sv
// Shared encodings and datapath helpers for the CPU-to-IOB bridge.
// Helpers work on 64-bit lanes; callers truncate to their own DATA_W.
package cpu_iob_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_DONE
  } state_e;

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (off[0] == 1'b0);
      SZ_W:    ok = (off[1:0] == 2'b00);
      default: ok = (off == 3'b000);
    endcase
    return ok;
  endfunction

  function automatic logic [7:0] strb_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  // Replicate the LSB-aligned store data into every lane of its size.
  function automatic logic [63:0] repl_wdata(input logic [63:0] d, input logic [1:0] size);
    logic [63:0] r;
    case (size)
      SZ_B:    r = {8{d[7:0]}};
      SZ_H:    r = {4{d[15:0]}};
      SZ_W:    r = {2{d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] extract_lane(input logic [63:0] rdata, input logic [2:0] off,
                                               input logic [1:0] size, input logic sgn);
    logic [63:0] lane;
    logic [63:0] res;
    lane = rdata >> {off, 3'b000};
    case (size)
      SZ_B:    res = {{56{sgn & lane[7]}}, lane[7:0]};
      SZ_H:    res = {{48{sgn & lane[15]}}, lane[15:0]};
      SZ_W:    res = {{32{sgn & lane[31]}}, lane[31:0]};
      default: res = lane;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cpu_iob_wbuf.sv
// Posted-write buffer: first-word-fall-through synchronous FIFO.
// A pop and a push in the same cycle are both honoured, even when full.
module cpu_iob_wbuf
  import cpu_iob_pkg::*;
#(
  parameter int WIDTH   = 68,
  parameter int DEPTH_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             last_o
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] FULL_CNT = (DEPTH_W + 1)'(DEPTH);
  localparam logic [DEPTH_W:0] ONE_CNT  = (DEPTH_W + 1)'(1);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr_q;
  logic [DEPTH_W-1:0] rd_ptr_q;
  logic [DEPTH_W:0]   cnt_q;
  logic               do_push;
  logic               do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign last_o  = (cnt_q == ONE_CNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cpu_iob_bridge.sv
// CPU data port to IOB bridge: posted stores through a write buffer,
// blocking loads that wait for the buffer to drain, with lane steering.
module cpu_iob_bridge
  import cpu_iob_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int IOB_ADDR_W   = 30,
  parameter int WBUF_DEPTH_W = 2,
  parameter int TIMEOUT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [1:0]            cpu_size_i,
  input  logic                  cpu_signed_i,
  input  logic [ADDR_W-1:0]     cpu_addr_i,
  input  logic [DATA_W-1:0]     cpu_wdata_i,
  output logic                  cpu_stall_o,
  output logic [DATA_W-1:0]     cpu_rdata_o,
  output logic                  cpu_rvalid_o,
  output logic                  cpu_err_o,
  output logic                  iob_valid_o,
  output logic [IOB_ADDR_W-1:0] iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_ready_i,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i,
  output logic                  busy_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int ENT_W  = ADDR_W + DATA_W + STRB_W;

  state_e                state_q;
  logic [ADDR_W-1:0]     ld_addr_q;
  logic [1:0]            ld_size_q;
  logic                  ld_signed_q;
  logic [TIMEOUT_W-1:0]  tmo_q;
  logic                  tout_q;
  logic                  rvalid_q;
  logic                  err_q;
  logic [DATA_W-1:0]     rdata_q;

  logic [2:0]            req_off;
  logic [2:0]            ld_off;
  logic                  size_ok;
  logic                  misalign;
  logic                  can_take;
  logic                  bad_req;
  logic                  st_req;
  logic                  ld_req;
  logic [DATA_W-1:0]     wdata_rep;
  logic [STRB_W-1:0]     strb;
  logic [DATA_W-1:0]     rd_ext;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_last;
  logic [ENT_W-1:0]      fifo_din;
  logic [ENT_W-1:0]      fifo_dout;
  logic [ADDR_W-1:0]     head_addr;
  logic [DATA_W-1:0]     head_wdata;
  logic [STRB_W-1:0]     head_strb;

  assign req_off   = 3'(cpu_addr_i[OFF_W-1:0]);
  assign ld_off    = 3'(ld_addr_q[OFF_W-1:0]);
  assign size_ok   = (DATA_W == 64) || (cpu_size_i != SZ_D);
  assign misalign  = !size_ok || !is_aligned(cpu_size_i, req_off);

  // tout_q marks the cycle that retires a timed-out load; the CPU still
  // presents that load, so it must not be taken as a fresh request.
  assign can_take  = (state_q == ST_IDLE) && !tout_q && cpu_req_i;
  assign bad_req   = can_take && misalign;
  assign st_req    = can_take && !misalign && cpu_we_i;
  assign ld_req    = can_take && !misalign && !cpu_we_i;

  assign wdata_rep = DATA_W'(repl_wdata(64'(cpu_wdata_i), cpu_size_i));
  assign strb      = STRB_W'(strb_mask(cpu_size_i, req_off));
  assign rd_ext    = DATA_W'(extract_lane(64'(iob_rdata_i), ld_off, ld_size_q, ld_signed_q));

  assign fifo_din   = {cpu_addr_i, wdata_rep, strb};
  assign head_addr  = fifo_dout[ENT_W-1 -: ADDR_W];
  assign head_wdata = fifo_dout[STRB_W +: DATA_W];
  assign head_strb  = fifo_dout[STRB_W-1:0];

  assign fifo_pop  = ((state_q == ST_IDLE) || (state_q == ST_DRAIN)) && !fifo_empty && iob_ready_i;
  assign fifo_push = st_req && (!fifo_full || fifo_pop);

  cpu_iob_wbuf #(
    .WIDTH   (ENT_W),
    .DEPTH_W (WBUF_DEPTH_W)
  ) u_wbuf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .last_o  (fifo_last)
  );

  always_comb begin
    cpu_stall_o = 1'b0;
    case (state_q)
      ST_IDLE:    cpu_stall_o = ld_req || (st_req && fifo_full && !fifo_pop);
      ST_RD_DONE: cpu_stall_o = 1'b0;
      default:    cpu_stall_o = 1'b1;
    endcase
  end

  always_comb begin
    iob_valid_o = 1'b0;
    iob_addr_o  = '0;
    iob_wdata_o = '0;
    iob_wstrb_o = '0;
    if (state_q == ST_RD_REQ) begin
      iob_valid_o = 1'b1;
      iob_addr_o  = IOB_ADDR_W'(ld_addr_q >> OFF_W);
    end else if (((state_q == ST_IDLE) || (state_q == ST_DRAIN)) && !fifo_empty) begin
      iob_valid_o = 1'b1;
      iob_addr_o  = IOB_ADDR_W'(head_addr >> OFF_W);
      iob_wdata_o = head_wdata;
      iob_wstrb_o = head_strb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ld_addr_q   <= '0;
      ld_size_q   <= SZ_B;
      ld_signed_q <= 1'b0;
      tmo_q       <= '0;
      tout_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      err_q    <= bad_req;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      tout_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ld_req) begin
            ld_addr_q   <= cpu_addr_i;
            ld_size_q   <= cpu_size_i;
            ld_signed_q <= cpu_signed_i;
            state_q     <= fifo_empty ? ST_RD_REQ : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty || (fifo_pop && fifo_last)) begin
            state_q <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          if (iob_ready_i) begin
            if (iob_rvalid_i) begin
              rvalid_q <= 1'b1;
              rdata_q  <= rd_ext;
              state_q  <= ST_RD_DONE;
            end else begin
              tmo_q   <= '0;
              state_q <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (iob_rvalid_i) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_ext;
            state_q  <= ST_RD_DONE;
          end else if (&tmo_q) begin
            err_q   <= 1'b1;
            tout_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_rvalid_o = rvalid_q;
  assign cpu_rdata_o  = rdata_q;
  assign cpu_err_o    = err_q;
  assign busy_o       = (state_q != ST_IDLE) || !fifo_empty;

endmodule
